mem_stage: RTL and testbench

- Memory-access pipeline stage; sits directly downstream of the execute stage and consumes its ex_to_mem_bus.
- Registers the EX result. Returns load data from data SRAM and aligns/extends it, using a one-entry buffer so the data survives a stall.
- Selects the writeback value, drives the MEM->ID forwarding bus, and commits divider results into the architectural HI/LO registers.

---
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_stage.sv | 137 +++++++++++++
 tb/tb_mem_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Bundle between the execute stage, the memory stage and its consumers.
// Carries the stall vector, EX->MEM bus, SRAM read data and all MEM-side results.
// master = environment/EX side driving inputs; slave = the memory stage.
interface mem_stage_if #(
  parameter int STALL_W  = 6,
  parameter int EX_MEM_W = 141,
  parameter int MEM_WB_W = 70
);
  logic [STALL_W-1:0]  stall;
  logic [EX_MEM_W-1:0] ex_to_mem_bus;
  logic [2:0]          ex_mem_op;
  logic [31:0]         data_sram_rdata;
  logic [MEM_WB_W-1:0] mem_to_wb_bus;
  logic [37:0]         mem_to_id_forwarding;
  logic [31:0]         hi_o;
  logic [31:0]         lo_o;

  modport master (
    output stall, ex_to_mem_bus, ex_mem_op, data_sram_rdata,
    input  mem_to_wb_bus, mem_to_id_forwarding, hi_o, lo_o
  );

  modport slave (
    input  stall, ex_to_mem_bus, ex_mem_op, data_sram_rdata,
    output mem_to_wb_bus, mem_to_id_forwarding, hi_o, lo_o
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: registers EX result, aligns load data, commits HI/LO.
// Latency: one cycle EX->MEM register; writeback/forwarding buses are combinational from it.
// Backpressure: stall[3] holds or bubbles the stage; a one-entry buffer keeps load data across a hold.
module mem_stage #(
  parameter int STALL_W  = 6,
  parameter int EX_MEM_W = 141,
  parameter int MEM_WB_W = 70
) (
  input logic       clk,
  input logic       rst,
  mem_stage_if.slave pipe
);

  typedef struct packed {
    logic        div_valid;
    logic [63:0] div_result;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_bus_t;

  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  logic [STALL_W-1:0]  stall_vec;
  logic [EX_MEM_W-1:0] in_raw;
  ex_bus_t             in_bus;
  ex_bus_t             r;
  logic [2:0]          r_op;
  logic                fresh;
  logic [31:0]         rdata_buf;
  logic                buf_valid;
  logic [31:0]         hi;
  logic [31:0]         lo;

  logic                stop_mem;
  logic                stop_wb;
  logic                capture;
  logic                bubble;
  logic                is_load;

  logic [31:0]         ld_word;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         aligned;
  logic [31:0]         rf_wdata;
  logic [MEM_WB_W-1:0] wb_bus;
  logic                unused_stall_bits;

  assign stall_vec = pipe.stall;
  assign in_raw    = pipe.ex_to_mem_bus;
  assign in_bus    = in_raw;

  // Only the MEM and WB stop bits matter to this stage.
  assign unused_stall_bits = ^{stall_vec[STALL_W-1:5], stall_vec[2:0]};

  assign stop_mem = stall_vec[3];
  assign stop_wb  = stall_vec[4];
  assign bubble   = stop_mem & ~stop_wb;
  assign capture  = ~stop_mem;
  assign is_load  = r.data_ram_en & (r.data_ram_wen == 4'b0000);

  // Stage register: bubble beats capture, otherwise hold; fresh marks the first cycle after capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r     <= '0;
      r_op  <= '0;
      fresh <= 1'b0;
    end else if (bubble) begin
      r     <= '0;
      r_op  <= '0;
      fresh <= 1'b0;
    end else if (capture) begin
      r     <= in_bus;
      r_op  <= pipe.ex_mem_op;
      fresh <= 1'b1;
    end else begin
      fresh <= 1'b0;
    end
  end

  // Snapshot SRAM data once, in the first cycle of a stalled load; dropped when r moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_buf <= '0;
      buf_valid <= 1'b0;
    end else if (capture || bubble) begin
      buf_valid <= 1'b0;
    end else if (fresh && is_load && stop_mem) begin
      rdata_buf <= pipe.data_sram_rdata;
      buf_valid <= 1'b1;
    end
  end

  // Pick the live load word and align/extend it by load type and address low bits.
  always_comb begin
    ld_word = '0;
    if (fresh)          ld_word = pipe.data_sram_rdata;
    else if (buf_valid) ld_word = rdata_buf;
    ld_byte = ld_word[{r.ex_result[1:0], 3'b000} +: 8];
    ld_half = r.ex_result[1] ? ld_word[31:16] : ld_word[15:0];
    case (r_op)
      OP_LB:   aligned = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  aligned = {24'h0, ld_byte};
      OP_LH:   aligned = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  aligned = {16'h0, ld_half};
      default: aligned = ld_word;
    endcase
  end

  assign rf_wdata = r.sel_rf_res ? aligned : r.ex_result;
  assign wb_bus   = {r.pc, r.rf_we, r.rf_waddr, rf_wdata};

  assign pipe.mem_to_wb_bus        = wb_bus;
  assign pipe.mem_to_id_forwarding = {r.rf_we, r.rf_waddr, rf_wdata};

  // Commit divider results held in r; rewriting the same value during a hold is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (r.div_valid) begin
      hi <= r.div_result[63:32];
      lo <= r.div_result[31:0];
    end
  end

  assign pipe.hi_o = hi;
  assign pipe.lo_o = lo;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed cases plus randomized traffic against a transaction-level model.
// The model tracks the instruction sitting in MEM, its age, and the SRAM word seen in its first cycle.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_stage_if #(.STALL_W(6), .EX_MEM_W(141), .MEM_WB_W(70)) pipe ();

  mem_stage #(.STALL_W(6), .EX_MEM_W(141), .MEM_WB_W(70)) dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (pipe)
  );

  // Model: instruction in MEM, cycles since it entered, its load word, and architectural HI/LO.
  logic [140:0] m_bus;
  logic [2:0]   m_op;
  int           m_age;
  logic [31:0]  m_word;
  logic [31:0]  m_hi;
  logic [31:0]  m_lo;

  localparam logic [5:0] GO   = 6'b000000;
  localparam logic [5:0] HOLD = 6'b011000;
  localparam logic [5:0] BUBL = 6'b001000;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [140:0] mk(input logic dv, input logic [63:0] dr, input logic [31:0] pc,
                                      input logic en, input logic [3:0] wen, input logic sel,
                                      input logic we, input logic [4:0] wa, input logic [31:0] res);
    return {dv, dr, pc, en, wen, sel, we, wa, res};
  endfunction

  // Little-endian load extraction computed arithmetically from the load rules.
  function automatic logic [31:0] ref_align(input logic [2:0] op, input logic [1:0] a, input logic [31:0] w);
    int unsigned b;
    int unsigned h;
    int unsigned sh;
    sh = 8 * a;
    b  = (w >> sh) & 32'hFF;
    h  = a[1] ? (w >> 16) : (w & 32'hFFFF);
    case (op)
      3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [69:0] exp_wb(input logic [31:0] rd);
    logic [31:0] w;
    logic [31:0] wd;
    w  = (m_age == 0) ? rd : m_word;
    wd = m_bus[38] ? ref_align(m_op, m_bus[1:0], w) : m_bus[31:0];
    return {m_bus[75:44], m_bus[37], m_bus[36:32], wd};
  endfunction

  task automatic model_reset();
    m_bus  = '0;
    m_op   = '0;
    m_age  = 1;
    m_word = '0;
    m_hi   = '0;
    m_lo   = '0;
  endtask

  // Called at a negedge: apply inputs, let combinational outputs settle, compare with the model.
  task automatic drive_check(input logic [140:0] bus, input logic [2:0] op, input logic [5:0] st,
                             input logic [31:0] rd, input string tag);
    logic [69:0] e;
    pipe.ex_to_mem_bus   = bus;
    pipe.ex_mem_op       = op;
    pipe.stall           = st;
    pipe.data_sram_rdata = rd;
    #1;
    e = exp_wb(rd);
    check({tag, "_wb"}, pipe.mem_to_wb_bus, e);
    check({tag, "_fwd"}, {32'h0, pipe.mem_to_id_forwarding}, {32'h0, e[37:0]});
    check({tag, "_hilo"}, {6'h0, pipe.hi_o, pipe.lo_o}, {6'h0, m_hi, m_lo});
  endtask

  // Advance the model across the coming rising edge, then wait for the next negedge.
  task automatic advance();
    if (m_bus[140]) begin
      m_hi = m_bus[139:108];
      m_lo = m_bus[107:76];
    end
    if (m_age == 0 && m_bus[43] && m_bus[42:39] == 4'b0000) m_word = pipe.data_sram_rdata;
    if (!pipe.stall[3]) begin
      m_bus = pipe.ex_to_mem_bus;
      m_op  = pipe.ex_mem_op;
      m_age = 0;
    end else if (!pipe.stall[4]) begin
      m_bus  = '0;
      m_op   = '0;
      m_age  = 1;
      m_word = '0;
    end else begin
      m_age++;
    end
    @(negedge clk);
  endtask

  logic [140:0] nop;
  logic [140:0] alu;
  logic [140:0] ld;
  logic [2:0]   ld_op  [6];
  logic [1:0]   ld_adr [6];
  logic [31:0]  ld_exp [6];

  initial begin
    nop = '0;
    ld_op[0] = 3'd1; ld_adr[0] = 2'd1; ld_exp[0] = 32'h0000_007F;
    ld_op[1] = 3'd1; ld_adr[1] = 2'd2; ld_exp[1] = 32'hFFFF_FFFF;
    ld_op[2] = 3'd2; ld_adr[2] = 2'd3; ld_exp[2] = 32'h0000_0080;
    ld_op[3] = 3'd3; ld_adr[3] = 2'd2; ld_exp[3] = 32'hFFFF_80FF;
    ld_op[4] = 3'd4; ld_adr[4] = 2'd0; ld_exp[4] = 32'h0000_7F01;
    ld_op[5] = 3'd0; ld_adr[5] = 2'd0; ld_exp[5] = 32'h80FF_7F01;

    rst = 1'b1;
    pipe.ex_to_mem_bus   = '0;
    pipe.ex_mem_op       = '0;
    pipe.stall           = '0;
    pipe.data_sram_rdata = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_wb", pipe.mem_to_wb_bus, 70'h0);
    check("reset_hilo", {6'h0, pipe.hi_o, pipe.lo_o}, 70'h0);
    rst = 1'b0;

    // ALU pass-through
    alu = mk(1'b0, 64'h0, 32'h0000_1000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h1234_5678);
    drive_check(alu, 3'd0, GO, 32'h0, "alu_in");
    advance();
    drive_check(nop, 3'd0, GO, 32'h0, "alu");
    check("alu_wdata", {38'h0, pipe.mem_to_wb_bus[31:0]}, {38'h0, 32'h1234_5678});
    check("alu_waddr", {65'h0, pipe.mem_to_id_forwarding[36:32]}, {65'h0, 5'd5});
    advance();

    // Load alignment table
    for (int i = 0; i < 6; i++) begin
      ld = mk(1'b0, 64'h0, 32'h0000_2000 + 32'(i * 4), 1'b1, 4'h0, 1'b1, 1'b1, 5'd9,
              {30'h0000_0100, ld_adr[i]});
      drive_check(ld, ld_op[i], GO, 32'h1111_1111, "ld_in");
      advance();
      drive_check(nop, 3'd0, GO, 32'h80FF_7F01, "ld");
      check($sformatf("ld_const%0d", i), {38'h0, pipe.mem_to_wb_bus[31:0]}, {38'h0, ld_exp[i]});
      advance();
    end

    // Load held across a stall while SRAM data changes
    ld = mk(1'b0, 64'h0, 32'h0000_3000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'h0000_0040);
    drive_check(ld, 3'd0, GO, 32'h0, "lds_in");
    advance();
    drive_check(nop, 3'd0, HOLD, 32'hCAFE_BABE, "lds0");
    check("lds_first", {38'h0, pipe.mem_to_wb_bus[31:0]}, {38'h0, 32'hCAFE_BABE});
    advance();
    for (int i = 0; i < 3; i++) begin
      drive_check(nop, 3'd0, HOLD, 32'hDEAD_0000, "lds");
      check("lds_held", {38'h0, pipe.mem_to_wb_bus[31:0]}, {38'h0, 32'hCAFE_BABE});
      advance();
    end

    // Bubble and hold
    drive_check(alu, 3'd0, GO, 32'h0, "bub_in");
    advance();
    drive_check(nop, 3'd0, BUBL, 32'h0, "bub0");
    advance();
    drive_check(nop, 3'd0, HOLD, 32'h0, "bub");
    check("bubble_zero", pipe.mem_to_wb_bus, 70'h0);
    advance();
    drive_check(alu, 3'd0, GO, 32'h0, "hold_in");
    advance();
    for (int i = 0; i < 2; i++) begin
      drive_check(nop, 3'd0, HOLD, 32'h0, "hold");
      check("hold_keep", {38'h0, pipe.mem_to_wb_bus[31:0]}, {38'h0, 32'h1234_5678});
      advance();
    end

    // Divide commit and persistence
    drive_check(mk(1'b1, 64'h0000_0003_0000_0007, 32'h0000_4000, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h0),
                3'd0, GO, 32'h0, "div_in");
    advance();
    drive_check(alu, 3'd0, GO, 32'h0, "div0");
    advance();
    for (int i = 0; i < 3; i++) begin
      drive_check(alu, 3'd0, GO, 32'h0, "div");
      check("div_hilo", {6'h0, pipe.hi_o, pipe.lo_o}, {6'h0, 32'd3, 32'd7});
      advance();
    end

    // Asynchronous reset between edges with live state
    #2 rst = 1'b1;
    #1;
    check("areset_wb", pipe.mem_to_wb_bus, 70'h0);
    check("areset_fwd", {32'h0, pipe.mem_to_id_forwarding}, 70'h0);
    check("areset_hilo", {6'h0, pipe.hi_o, pipe.lo_o}, 70'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic        is_ld;
      logic        is_st;
      logic [5:0]  st;
      logic [140:0] b;
      is_ld = ($urandom_range(0, 2) == 0);
      is_st = !is_ld && ($urandom_range(0, 3) == 0);
      b = mk($urandom_range(0, 3) == 0, {$urandom, $urandom}, $urandom, is_ld | is_st,
             is_st ? 4'($urandom_range(1, 15)) : 4'h0, is_ld, 1'($urandom), 5'($urandom), $urandom);
      st = 6'($urandom);
      st[3] = ($urandom_range(0, 2) == 0);
      drive_check(b, 3'($urandom), st, $urandom, "rnd");
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
